ram_io_responder: RTL and testbench
===================================

RAM_IO_RESPONDER -- requirements
Module: ram_io_responder

Interface
REQ-001 Parameter RAM_AW, default 17, SHALL give byte RAM depth as 2^RAM_AW.
REQ-002 Parameter FIFO_DEPTH, default 8, power of two >= 4, SHALL give the IO transmit FIFO entries.
REQ-003 clk  input  1  the single clock; all state SHALL update on posedge clk.
REQ-004 rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 mem_a  input  32  byte address from the initiator.
REQ-006 mem_dout  input  8  write byte from the initiator.
REQ-007 mem_wr  input  1  1 = write cycle, 0 = read cycle.
REQ-008 mem_din  output  8  read byte returned to the initiator.
REQ-009 io_buffer_full  output  1  IO write back-pressure to the initiator.
REQ-010 tx_data  output  8, tx_valid  output  1, tx_ready  input  1: output byte stream.
REQ-011 err_overflow  output  1  sticky flag, set on a dropped IO write.
REQ-012 rx_data  input  8, rx_valid  input  1, rx_ready  output  1: input byte stream, present only under IO_RX_EN.

Function
REQ-013 IO region SHALL be mem_a[17:16]==2'b11; all other addresses SHALL map to RAM at mem_a[RAM_AW-1:0].
REQ-014 Each RAM write (mem_wr=1) SHALL store mem_dout at posedge.
REQ-015 Each read (mem_wr=0) SHALL register mem_din from the address presented that cycle; data is valid exactly 1 cycle later.
REQ-016 Read-after-write to the same address on consecutive cycles SHALL return the new byte.
REQ-017 A write to IO address 0x30000 SHALL push mem_dout into the TX FIFO when the FIFO is not full.
REQ-018 A write to 0x30000 while the FIFO is full SHALL be dropped and set err_overflow.
REQ-019 Writes to other IO addresses SHALL be ignored.
REQ-020 Reads of IO addresses without IO_RX_EN SHALL return 8'h00.
REQ-021 io_buffer_full SHALL be registered and SHALL be 1 when the post-update FIFO count >= FIFO_DEPTH-1, giving one entry of slack for a write already in flight.
REQ-022 tx_valid SHALL equal FIFO not empty; tx_data SHALL be the FIFO head; the FIFO SHALL pop on tx_valid&&tx_ready.
REQ-023 A simultaneous push and pop SHALL be allowed at any count, including full, leaving the count unchanged.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be FIFO_DEPTH-width+1 bits.

Reset
REQ-025 On rst low the block SHALL set mem_din=0, io_buffer_full=0, tx_valid=0, err_overflow=0, rx_ready=0, and FIFO pointers/count to 0, immediately and regardless of clk.
REQ-026 RAM contents SHALL NOT be reset.
REQ-027 A byte in the FIFO at reset SHALL be discarded.

Configuration
REQ-028 Macro IO_RX_EN defined: an IO read of 0x30000 SHALL return rx_data if rx_valid, else 8'h00, and SHALL pulse rx_ready for that cycle to consume the byte.
REQ-029 Macro IO_RX_EN defined: an IO read of 0x30004 SHALL return {7'b0, rx_valid}.
REQ-030 Macro IO_RX_EN undefined: the rx ports SHALL be absent and REQ-020 SHALL apply.

Structure
REQ-031 Shared package ram_io_pkg SHALL hold IO_BASE=32'h30000, IO_RX_DATA=32'h30000, IO_RX_STAT=32'h30004, and the IO-region decode constant.
REQ-032 TX FIFO SHALL be the sub-module io_tx_fifo (push, pop, data, count, full, empty).

Verification
REQ-033 Write 8'hA5 to 0x00010, then read 0x00010 on the next cycle -> mem_din=8'hA5 one cycle after the read address.
REQ-034 Write bytes 0x01..0x07 to 0x30000 with tx_ready=0 -> io_buffer_full=1 after the 7th push; an 8th write is accepted; a 9th write sets err_overflow=1 and FIFO holds 0x01..0x08.
REQ-035 Full FIFO, tx_ready=1 and a push the same cycle -> count stays 8, and tx_data sequence continues 0x02, 0x03, ...
REQ-036 Assert rst low mid-burst with 3 bytes queued -> tx_valid=0 and io_buffer_full=0 immediately; the previously written RAM byte still reads back.
REQ-037 IO_RX_EN, rx_valid=1, rx_data=8'h5A, read 0x30000 -> mem_din=8'h5A and rx_ready pulses for 1 cycle; with rx_valid=0 -> mem_din=8'h00.
REQ-038 Read 0x30000 without IO_RX_EN -> mem_din=8'h00.

Source files
------------

// File: rtl/ram_io_pkg.sv
// Shared address map and request payload for the RAM/IO responder.
// Optional RX stream support is selected with the IO_RX_EN macro.
package ram_io_pkg;

  localparam logic [31:0] IO_BASE    = 32'h0003_0000;
  localparam logic [31:0] IO_RX_DATA = 32'h0003_0000;
  localparam logic [31:0] IO_RX_STAT = 32'h0003_0004;
  localparam logic [1:0]  IO_REGION  = 2'b11;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  wdata;
    logic        wr;
  } mem_req_t;

  // Region decode uses only mem_a[17:16].
  function automatic logic is_io(input logic [1:0] sel);
    return sel == IO_REGION;
  endfunction

endpackage

// File: rtl/ram_io_responder_if.sv
// Initiator memory bus plus TX (and, with IO_RX_EN, RX) byte streams.
// master = initiator / stream peer side, slave = the responder.
interface ram_io_responder_if;

  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        err_overflow;
`ifdef IO_RX_EN
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
`endif

  modport master (
    output mem_a, mem_dout, mem_wr, tx_ready,
    input  mem_din, io_buffer_full, tx_data, tx_valid, err_overflow
`ifdef IO_RX_EN
    , output rx_data, rx_valid
    , input  rx_ready
`endif
  );

  modport slave (
    input  mem_a, mem_dout, mem_wr, tx_ready,
    output mem_din, io_buffer_full, tx_data, tx_valid, err_overflow
`ifdef IO_RX_EN
    , input  rx_data, rx_valid
    , output rx_ready
`endif
  );

endinterface

// File: rtl/io_tx_fifo.sv
// Byte FIFO for the IO transmit path; push and pop may coincide at any count.
module io_tx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [7:0]                 wdata,
  output logic [7:0]                 data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0]    store [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  // Guard locally so a misbehaving caller cannot corrupt the pointers.
  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != CW'(DEPTH)) || do_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; stale bytes are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= wdata;
  end

  assign data  = store[rd_ptr];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/ram_io_responder.sv
// Byte RAM with a memory-mapped IO window: TX FIFO at IO_BASE and,
// when IO_RX_EN is defined, an RX data/status pair.
module ram_io_responder
  import ram_io_pkg::*;
#(
  parameter int unsigned RAM_AW     = 17,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input logic               clk,
  input logic               rst,
  ram_io_responder_if.slave bus
);

  localparam int unsigned RAM_BYTES = 1 << RAM_AW;
  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    ram [RAM_BYTES];
  mem_req_t      req;
  logic          io_sel;
  logic          tx_wr;
  logic          pop_acc;
  logic          push_acc;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_nxt;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    rd_data_c;

  assign req = '{a: bus.mem_a, wdata: bus.mem_dout, wr: bus.mem_wr};

  // Decode and FIFO acceptance; a full FIFO still accepts when it pops this cycle.
  always_comb begin
    io_sel    = is_io(req.a[17:16]);
    tx_wr     = req.wr && io_sel && (req.a == IO_BASE);
    pop_acc   = !fifo_empty && bus.tx_ready;
    push_acc  = tx_wr && (!fifo_full || pop_acc);
    count_nxt = fifo_count + CW'(push_acc) - CW'(pop_acc);
  end

  // Read mux; IO reads default to zero.
  always_comb begin
    rd_data_c = 8'h00;
    if (!io_sel) begin
      rd_data_c = ram[req.a[RAM_AW-1:0]];
`ifdef IO_RX_EN
    end else if (req.a == IO_RX_DATA) begin
      rd_data_c = bus.rx_valid ? bus.rx_data : 8'h00;
    end else if (req.a == IO_RX_STAT) begin
      rd_data_c = {7'b0, bus.rx_valid};
`endif
    end
  end

`ifdef IO_RX_EN
  // Consume the RX byte in the same cycle its data register is read.
  assign bus.rx_ready = rst && !req.wr && io_sel && (req.a == IO_RX_DATA);
`endif

  always_ff @(posedge clk) begin
    if (req.wr && !io_sel) ram[req.a[RAM_AW-1:0]] <= req.wdata;
  end

  // mem_din holds its value across write cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mem_din        <= 8'h00;
      bus.io_buffer_full <= 1'b0;
      bus.err_overflow   <= 1'b0;
    end else begin
      if (!req.wr) bus.mem_din <= rd_data_c;
      bus.io_buffer_full <= (count_nxt >= CW'(FIFO_DEPTH - 1));
      if (tx_wr && !push_acc) bus.err_overflow <= 1'b1;
    end
  end

  io_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_acc),
    .pop   (pop_acc),
    .wdata (req.wdata),
    .data  (bus.tx_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.tx_valid = !fifo_empty;

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed bench for ram_io_responder: vector table plus FIFO/reset/RX sequences.
module tb_ram_io_responder;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  ram_io_responder_if bus ();

  ram_io_responder #(
    .RAM_AW     (17),
    .FIFO_DEPTH (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  dout;
    logic        chk_din;
    logic [7:0]  exp_din;
    logic        exp_full;
    logic        exp_tv;
    logic [7:0]  exp_td;
    logic        exp_err;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [31:0] addr, input logic [7:0] dout);
    bus.mem_wr   = wr;
    bus.mem_a    = addr;
    bus.mem_dout = dout;
  endtask

  task automatic add(input logic wr, input logic [31:0] addr, input logic [7:0] dout,
                     input logic chk_din, input logic [7:0] exp_din, input logic exp_full,
                     input logic exp_tv, input logic [7:0] exp_td, input logic exp_err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.dout = dout; v.chk_din = chk_din; v.exp_din = exp_din;
    v.exp_full = exp_full; v.exp_tv = exp_tv; v.exp_td = exp_td; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  logic [7:0] pop_exp  [7];
  logic       pop_full [7];

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    bus.tx_ready = 1'b0;
    drive(1'b0, 32'h0, 8'h00);
`ifdef IO_RX_EN
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
`endif

    // RAM traffic, ignored IO writes, IO reads, then fill the FIFO past full.
    add(1, 32'h0001_0000 >> 12, 8'hA5, 1, 8'h00, 0, 0, 8'h00, 0); // write 0x10
    add(0, 32'h0000_0010, 8'h00, 1, 8'hA5, 0, 0, 8'h00, 0);
    add(1, 32'h0000_0020, 8'h3C, 1, 8'hA5, 0, 0, 8'h00, 0);
    add(0, 32'h0000_0020, 8'h00, 1, 8'h3C, 0, 0, 8'h00, 0);
    add(0, 32'h0000_0010, 8'h00, 1, 8'hA5, 0, 0, 8'h00, 0);
    add(1, 32'h0001_0000, 8'h11, 1, 8'hA5, 0, 0, 8'h00, 0);
    add(1, 32'h0013_0000, 8'hEE, 1, 8'hA5, 0, 0, 8'h00, 0);
    add(0, 32'h0001_0000, 8'h00, 1, 8'h11, 0, 0, 8'h00, 0);
    add(1, 32'h0003_0004, 8'h77, 1, 8'h11, 0, 0, 8'h00, 0);
    add(0, 32'h0003_0000, 8'h00, 1, 8'h00, 0, 0, 8'h00, 0);
    add(0, 32'h0000_0010, 8'h00, 1, 8'hA5, 0, 0, 8'h00, 0);
    add(0, 32'h0003_0004, 8'h00, 1, 8'h00, 0, 0, 8'h00, 0);
    for (int k = 1; k <= 7; k++)
      add(1, 32'h0003_0000, 8'(k), 1, 8'h00, (k == 7), 1, 8'h01, 0);
    add(1, 32'h0003_0000, 8'h08, 1, 8'h00, 1, 1, 8'h01, 0);
    add(1, 32'h0003_0000, 8'h09, 1, 8'h00, 1, 1, 8'h01, 1);

    // Reset state, checked while rst is held low.
    repeat (2) @(negedge clk);
    chk("rst_din",  bus.mem_din, 8'h00);
    chk("rst_full", {7'b0, bus.io_buffer_full}, 8'h00);
    chk("rst_tv",   {7'b0, bus.tx_valid}, 8'h00);
    chk("rst_err",  {7'b0, bus.err_overflow}, 8'h00);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].addr, vecs[i].dout);
      @(negedge clk);
      if (vecs[i].chk_din) chk($sformatf("v%0d_din", i), bus.mem_din, vecs[i].exp_din);
      chk($sformatf("v%0d_full", i), {7'b0, bus.io_buffer_full}, {7'b0, vecs[i].exp_full});
      chk($sformatf("v%0d_tv", i),   {7'b0, bus.tx_valid}, {7'b0, vecs[i].exp_tv});
      if (vecs[i].exp_tv) chk($sformatf("v%0d_td", i), bus.tx_data, vecs[i].exp_td);
      chk($sformatf("v%0d_err", i),  {7'b0, bus.err_overflow}, {7'b0, vecs[i].exp_err});
    end

    // Full FIFO: pop and push in the same cycle keeps it full and advances the head.
    bus.tx_ready = 1'b1;
    drive(1'b1, 32'h0003_0000, 8'h0A);
    @(negedge clk);
    chk("pp_td",   bus.tx_data, 8'h02);
    chk("pp_full", {7'b0, bus.io_buffer_full}, 8'h01);
    chk("pp_err",  {7'b0, bus.err_overflow}, 8'h01);

    // Drain: remaining bytes in order, then empty.
    pop_exp  = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
    pop_full = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    drive(1'b0, 32'h0000_0010, 8'h00);
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      chk($sformatf("drain%0d_td", j), bus.tx_data, pop_exp[j]);
      chk($sformatf("drain%0d_full", j), {7'b0, bus.io_buffer_full}, {7'b0, pop_full[j]});
    end
    @(negedge clk);
    chk("drain_empty", {7'b0, bus.tx_valid}, 8'h00);
    chk("drain_din",   bus.mem_din, 8'hA5);

    // Asynchronous reset with three bytes queued.
    bus.tx_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h0003_0000, 8'(8'h21 + k));
      @(negedge clk);
    end
    chk("q3_tv", {7'b0, bus.tx_valid}, 8'h01);
    chk("q3_td", bus.tx_data, 8'h21);
    drive(1'b0, 32'h0000_0010, 8'h00);
    #2 rst = 1'b0;
    #1;
    chk("arst_tv",   {7'b0, bus.tx_valid}, 8'h00);
    chk("arst_full", {7'b0, bus.io_buffer_full}, 8'h00);
    chk("arst_err",  {7'b0, bus.err_overflow}, 8'h00);
    chk("arst_din",  bus.mem_din, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ram10", bus.mem_din, 8'hA5);
    drive(1'b0, 32'h0000_0020, 8'h00);
    @(negedge clk);
    chk("post_rst_ram20", bus.mem_din, 8'h3C);
    chk("post_rst_tv", {7'b0, bus.tx_valid}, 8'h00);
    drive(1'b1, 32'h0003_0000, 8'h44);
    @(negedge clk);
    chk("post_rst_td", bus.tx_data, 8'h44);

`ifdef IO_RX_EN
    // RX data read consumes the byte; status reflects rx_valid.
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h5A;
    drive(1'b0, 32'h0003_0000, 8'h00);
    #1 chk("rx_ready_hi", {7'b0, bus.rx_ready}, 8'h01);
    @(negedge clk);
    chk("rx_din", bus.mem_din, 8'h5A);
    drive(1'b0, 32'h0003_0004, 8'h00);
    #1 chk("rx_ready_lo", {7'b0, bus.rx_ready}, 8'h00);
    @(negedge clk);
    chk("rx_stat", bus.mem_din, 8'h01);
    bus.rx_valid = 1'b0;
    drive(1'b0, 32'h0003_0000, 8'h00);
    @(negedge clk);
    chk("rx_empty_din", bus.mem_din, 8'h00);
`else
    drive(1'b0, 32'h0000_0010, 8'h00);
    @(negedge clk);
    drive(1'b0, 32'h0003_0000, 8'h00);
    @(negedge clk);
    chk("io_rd_zero", bus.mem_din, 8'h00);
`endif

    drive(1'b0, 32'h0, 8'h00);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
